// File: rtl/image_pipe_v2.sv
// rtl/image_pipe_v2.sv - multi-lane pixel stage: input buffer, per-lane gain/offset/saturate, stall-absorbing output register
module image_pipe_v2 #(
    parameter int DW     = 8,
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*DW-1:0] image_pipe_data_in,
    input  logic                 image_pipe_valid_in,
    input  logic                 image_pipe_end_in,
    output logic                 image_pipe_busy_out,
    output logic [NUM_CH*DW-1:0] image_pipe_data_out,
    output logic                 image_pipe_valid_out,
    output logic                 image_pipe_end_out,
    input  logic                 image_pipe_busy_in,
    input  logic                 reg_cpu_cs,
    input  logic                 reg_cpu_we,
    input  logic                 reg_cpu_re,
    input  logic [31:2]          reg_cpu_addr,
    input  logic [31:0]          reg_cpu_data_wr,
    output logic [31:0]          reg_cpu_data_rd,
    output logic                 reg_cpu_wack,
    output logic                 reg_cpu_rdv
);
    localparam int W  = NUM_CH * DW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] HIGH_LVL = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [13:0] ADDR_CTRL   = 14'h0;
    localparam logic [13:0] ADDR_GAIN   = 14'h1;
    localparam logic [13:0] ADDR_OFFSET = 14'h2;
    localparam logic [13:0] ADDR_STATUS = 14'h3;

    logic          enable_q, enable_d, bypass_q, ovf_q;
    logic [7:0]    gain_q, offset_q;
    logic [15:0]   frame_cnt_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q, level, level_d;
    logic [W:0]    mem_q [DEPTH];
    logic [W:0]    head;
    logic [W-1:0]  proc_data, data_q;
    logic          valid_q, end_q, busy_q;
    logic          push, pop, accept_out, wr_en, rd_req, rd_req_q;
    logic [13:0]   reg_idx;
    logic [31:0]   rd_mux, rd_data_q;
    logic          wack_q, rdv_q;
    logic [DW-1:0] lane;
    logic [DW+7:0] prod;
    logic [DW+5:0] sum;
    logic          unused_bits;

    assign unused_bits = ^{reg_cpu_addr[31:16], reg_cpu_data_wr[31:17], reg_cpu_data_wr[15:8]};

    assign reg_idx    = reg_cpu_addr[15:2];
    assign wr_en      = reg_cpu_cs && reg_cpu_we;
    assign rd_req     = reg_cpu_cs && reg_cpu_re;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign accept_out = valid_q && !image_pipe_busy_in;
    assign pop        = (level != '0) && (!valid_q || !image_pipe_busy_in);
    // A pop in the same cycle frees a slot, so a full buffer can still take a beat.
    assign push       = image_pipe_valid_in && enable_q && ((level != FULL_LVL) || pop);
    assign level_d    = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign enable_d   = (wr_en && reg_idx == ADDR_CTRL) ? reg_cpu_data_wr[0] : enable_q;

    always_comb begin
        proc_data = '0;
        lane      = '0;
        prod      = '0;
        sum       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            lane = head[k*DW +: DW];
            prod = {8'd0, lane} * {{DW{1'b0}}, gain_q};
            sum  = (DW+6)'(prod >> 4) + {{(DW-2){offset_q[7]}}, offset_q};
            if (bypass_q)
                proc_data[k*DW +: DW] = lane;
            else if (sum[DW+5])
                proc_data[k*DW +: DW] = '0;
            else if (|sum[DW+4:DW])
                proc_data[k*DW +: DW] = '1;
            else
                proc_data[k*DW +: DW] = sum[DW-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            ADDR_CTRL:   rd_mux = {30'd0, bypass_q, enable_q};
            ADDR_GAIN:   rd_mux = {24'd0, gain_q};
            ADDR_OFFSET: rd_mux = {24'd0, offset_q};
            ADDR_STATUS: rd_mux = {8'(level), 7'd0, ovf_q, frame_cnt_q};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= {image_pipe_end_in, image_pipe_data_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q    <= 1'b1;
            bypass_q    <= 1'b0;
            gain_q      <= 8'h10;
            offset_q    <= 8'h00;
            ovf_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            end_q       <= 1'b0;
            rd_data_q   <= 32'd0;
            rd_req_q    <= 1'b0;
            wack_q      <= 1'b0;
            rdv_q       <= 1'b0;
        end else begin
            enable_q <= enable_d;
            if (wr_en && reg_idx == ADDR_CTRL)   bypass_q <= reg_cpu_data_wr[1];
            if (wr_en && reg_idx == ADDR_GAIN)   gain_q   <= reg_cpu_data_wr[7:0];
            if (wr_en && reg_idx == ADDR_OFFSET) offset_q <= reg_cpu_data_wr[7:0];
            // A new drop wins over a simultaneous clear so no overflow event is lost.
            if (image_pipe_valid_in && !push)
                ovf_q <= 1'b1;
            else if (wr_en && reg_idx == ADDR_STATUS && reg_cpu_data_wr[16])
                ovf_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            busy_q <= (level_d >= HIGH_LVL) || !enable_d;
            if (pop) begin
                data_q  <= proc_data;
                valid_q <= 1'b1;
                end_q   <= head[W];
            end else if (accept_out) begin
                valid_q <= 1'b0;
                end_q   <= 1'b0;
            end
            if (accept_out && end_q) frame_cnt_q <= frame_cnt_q + 16'd1;
            rd_req_q <= rd_req;
            if (rd_req && !rd_req_q) rd_data_q <= rd_mux;
            wack_q <= wr_en;
            rdv_q  <= rd_req;
        end
    end

    assign image_pipe_busy_out  = busy_q;
    assign image_pipe_data_out  = data_q;
    assign image_pipe_valid_out = valid_q;
    assign image_pipe_end_out   = end_q;
    assign reg_cpu_data_rd      = rd_data_q;
    assign reg_cpu_wack         = wack_q;
    assign reg_cpu_rdv          = rdv_q;
endmodule

// File: tb/tb_image_pipe_v2.sv
// tb/tb_image_pipe_v2.sv - randomized self-checking bench for image_pipe_v2 against a queue-based reference model
module tb_image_pipe_v2;
    localparam int DW = 8, NUM_CH = 3, DEPTH = 8, W = NUM_CH * DW, PMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  data_in, data_out;
    logic          valid_in, end_in, busy_out, valid_out, end_out, busy_in;
    logic          reg_cpu_cs, reg_cpu_we, reg_cpu_re, reg_cpu_wack, reg_cpu_rdv;
    logic [31:2]   reg_cpu_addr;
    logic [31:0]   reg_cpu_data_wr, reg_cpu_data_rd;

    image_pipe_v2 #(.DW(DW), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .image_pipe_data_in(data_in), .image_pipe_valid_in(valid_in), .image_pipe_end_in(end_in),
        .image_pipe_busy_out(busy_out), .image_pipe_data_out(data_out),
        .image_pipe_valid_out(valid_out), .image_pipe_end_out(end_out), .image_pipe_busy_in(busy_in),
        .reg_cpu_cs(reg_cpu_cs), .reg_cpu_we(reg_cpu_we), .reg_cpu_re(reg_cpu_re),
        .reg_cpu_addr(reg_cpu_addr), .reg_cpu_data_wr(reg_cpu_data_wr), .reg_cpu_data_rd(reg_cpu_data_rd),
        .reg_cpu_wack(reg_cpu_wack), .reg_cpu_rdv(reg_cpu_rdv)
    );

    int          n_checks = 0, n_fail = 0;
    logic [W:0]  exp_q[$];
    logic [W:0]  mon_e;
    int          m_gain, m_off, exp_frames;
    bit          m_byp;
    logic        prev_valid, prev_busy, prev_end;
    logic [W-1:0] prev_data;
    logic [31:0] s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_beat(input logic [W-1:0] d);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v = int'(d[k*DW +: DW]);
            if (!m_byp) begin
                v = (v * m_gain) / 16 + m_off;
                if (v < 0) v = 0;
                if (v > PMAX) v = PMAX;
            end
            r[k*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && prev_busy) begin
                check_eq("hold_valid", 32'(valid_out), 1);
                check_eq("hold_data", 32'(data_out), 32'(prev_data));
                check_eq("hold_end", 32'(end_out), 32'(prev_end));
            end
            if (valid_out && !busy_in) begin
                check_eq("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_data", 32'(data_out), 32'(mon_e[W-1:0]));
                    check_eq("out_end", 32'(end_out), 32'(mon_e[W]));
                end
            end
            prev_valid = valid_out;
            prev_busy  = busy_in;
            prev_data  = data_out;
            prev_end   = end_out;
        end
    end

    task automatic do_reset();
        rst = 1'b1; valid_in = 0; end_in = 0; busy_in = 0;
        reg_cpu_cs = 0; reg_cpu_we = 0; reg_cpu_re = 0;
        #1;
        check_eq("rst_busy_out", 32'(busy_out), 0);
        check_eq("rst_valid_out", 32'(valid_out), 0);
        check_eq("rst_data_out", 32'(data_out), 0);
        check_eq("rst_end_out", 32'(end_out), 0);
        check_eq("rst_data_rd", reg_cpu_data_rd, 0);
        check_eq("rst_wack", 32'(reg_cpu_wack), 0);
        check_eq("rst_rdv", 32'(reg_cpu_rdv), 0);
        exp_q.delete();
        m_gain = 16; m_off = 0; m_byp = 0; exp_frames = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_write(input int idx, input logic [31:0] d);
        reg_cpu_cs = 1; reg_cpu_we = 1; reg_cpu_addr = 30'(idx); reg_cpu_data_wr = d;
        @(posedge clk); #1;
        reg_cpu_cs = 0; reg_cpu_we = 0;
        check_eq("wack", 32'(reg_cpu_wack), 1);
        if (idx == 0) m_byp = d[1];
        if (idx == 1) m_gain = int'(d[7:0]);
        if (idx == 2) m_off = int'($signed(d[7:0]));
        @(posedge clk); #1;
        check_eq("wack_pulse", 32'(reg_cpu_wack), 0);
    endtask

    task automatic cpu_read(input int idx, output logic [31:0] d);
        reg_cpu_cs = 1; reg_cpu_re = 1; reg_cpu_addr = 30'(idx);
        @(posedge clk); #1;
        reg_cpu_cs = 0; reg_cpu_re = 0;
        check_eq("rdv", 32'(reg_cpu_rdv), 1);
        d = reg_cpu_data_rd;
        @(posedge clk); #1;
    endtask

    task automatic wait_not_busy();
        int w = 0;
        while (busy_out === 1'b1 && w < 300) begin
            @(posedge clk); #1; w++;
        end
        if (w == 300) check_eq("busy_wait", 32'(busy_out), 0);
    endtask

    task automatic send_stream(input int n, input int frame_len, input bit honor, input int keep);
        logic [W-1:0] d;
        logic e;
        for (int i = 0; i < n; i++) begin
            d = W'($urandom);
            e = (frame_len > 0) ? ((i % frame_len) == frame_len - 1) : ($urandom_range(4) == 0);
            if (honor) wait_not_busy();
            valid_in = 1; data_in = d; end_in = e;
            if (honor || i < keep) begin
                exp_q.push_back({e, model_beat(d)});
                if (e) exp_frames++;
            end
            @(posedge clk); #1;
            valid_in = 0; end_in = 0;
            if (honor && $urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_one_check(input logic [W-1:0] d, input logic [W-1:0] expv);
        exp_q.push_back({1'b0, model_beat(d)});
        valid_in = 1; data_in = d; end_in = 0;
        @(posedge clk); #1;
        valid_in = 0;
        check_eq("lat_n1_valid", 32'(valid_out), 0);
        @(posedge clk); #1;
        check_eq("lat_n2_valid", 32'(valid_out), 1);
        check_eq("lat_n2_data", 32'(data_out), 32'(expv));
        @(posedge clk); #1;
    endtask

    task automatic random_busy(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            busy_in = ($urandom_range(2) == 0);
            @(posedge clk); #1;
        end
        busy_in = 0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 0; valid_in = 0; end_in = 0; busy_in = 0; data_in = '0;
        reg_cpu_cs = 0; reg_cpu_we = 0; reg_cpu_re = 0; reg_cpu_addr = '0; reg_cpu_data_wr = '0;
        prev_valid = 0; prev_busy = 0; prev_end = 0; prev_data = '0;
        #2;
        do_reset();

        cpu_read(0, s); check_eq("def_ctrl", s, 32'h1);
        cpu_read(1, s); check_eq("def_gain", s, 32'h10);
        cpu_read(2, s); check_eq("def_offset", s, 32'h0);
        cpu_read(3, s); check_eq("def_status", s, 32'h0);
        cpu_read(7, s); check_eq("unmapped", s, 32'h0);

        cpu_write(1, 32'h20);
        cpu_write(2, 32'hFB);
        send_one_check(24'h039040, 24'h01FF7B);
        cpu_write(1, 32'h10);
        send_one_check(24'h400340, 24'h3B003B);

        cpu_write(1, 32'($urandom_range(255)));
        cpu_write(2, 32'($urandom_range(255)));
        fork
            send_stream(40, 0, 1, 0);
            random_busy(120);
        join
        wait_drain();
        cpu_read(3, s);
        check_eq("rand_ovf", 32'(s[16]), 0);
        check_eq("rand_frames", 32'(s[15:0]), 32'(exp_frames));

        fork
            send_stream(12, 0, 1, 0);
            begin
                repeat (3) @(posedge clk);
                #1 busy_in = 1;
                repeat (10) @(posedge clk);
                #1 busy_in = 0;
            end
        join
        wait_drain();
        cpu_read(3, s);
        check_eq("stall_ovf", 32'(s[16]), 0);
        check_eq("stall_frames", 32'(s[15:0]), 32'(exp_frames));

        busy_in = 1;
        send_stream(DEPTH + 3, 1000, 0, DEPTH + 1);
        cpu_read(3, s);
        check_eq("ovf_set", 32'(s[16]), 1);
        check_eq("ovf_level", 32'(s[31:24]), DEPTH);
        busy_in = 0;
        wait_drain();
        cpu_write(3, 32'h10000);
        cpu_read(3, s);
        check_eq("ovf_clear", 32'(s[16]), 0);

        cpu_write(0, 32'h0);
        check_eq("dis_busy", 32'(busy_out), 1);
        send_stream(1, 1000, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        cpu_read(3, s);
        check_eq("dis_ovf", 32'(s[16]), 1);
        cpu_write(0, 32'h1);
        cpu_write(3, 32'h10000);
        check_eq("en_busy", 32'(busy_out), 0);

        send_stream(3, 1000, 1, 0);
        do_reset();
        cpu_read(0, s); check_eq("mid_rst_ctrl", s, 32'h1);
        cpu_read(1, s); check_eq("mid_rst_gain", s, 32'h10);
        cpu_read(3, s); check_eq("mid_rst_status", s, 32'h0);

        cpu_write(0, 32'h3);
        s = $urandom;
        send_one_check(W'(s), W'(s));
        send_stream(12, 4, 1, 0);
        wait_drain();
        cpu_read(3, s);
        check_eq("frame_count", 32'(s[15:0]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
